// File: rtl/sync_drive_split3.sv
// sync_drive_split3: takes words from a valid/ready stream into a 2-entry FIFO.
// Each word is split into three lanes, and one registered drive pulse is fired on
// all lanes together. Lane data then holds until all three free returns have been
// seen. A watchdog parks the FSM in ERR if a free never comes back.
//
// Handshake: a word transfers on any rising clk edge where i_valid && o_ready.
// o_ready depends only on registered FIFO occupancy. It never depends
// combinationally on i_valid. i_data must be stable while i_valid is high.
module sync_drive_split3 #(
  parameter int DATA_WIDTH_I0 = 1,
  parameter int DATA_WIDTH_I1 = 3,
  parameter int DATA_WIDTH_I2 = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                                                 clk,
  input  logic                                                 rstn,
  input  logic                                                 i_valid,
  output logic                                                 o_ready,
  input  logic [DATA_WIDTH_I0+DATA_WIDTH_I1+DATA_WIDTH_I2-1:0] i_data,
  output logic                                                 o_drive0,
  output logic                                                 o_drive1,
  output logic                                                 o_drive2,
  output logic [DATA_WIDTH_I0-1:0]                             o_data0,
  output logic [DATA_WIDTH_I1-1:0]                             o_data1,
  output logic [DATA_WIDTH_I2-1:0]                             o_data2,
  input  logic                                                 i_free0,
  input  logic                                                 i_free1,
  input  logic                                                 i_free2,
  input  logic                                                 i_clr_timeout,
  output logic                                                 o_busy,
  output logic                                                 o_timeout,
  output logic [1:0]                                           o_dbg_state
);

  localparam int W      = DATA_WIDTH_I0 + DATA_WIDTH_I1 + DATA_WIDTH_I2;
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push;
  logic         pop;
  logic [W-1:0] head;

  // ---------------------------------------------------------------------------
  // Free-return synchronizers and edge detectors
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [SYNC_STAGES-1:0] sync_d [3];
  logic [2:0]             free_in;
  logic [2:0]             sync_out;
  logic [2:0]             dly_q, dly_d;
  logic [2:0]             free_edge;

  // ---------------------------------------------------------------------------
  // FSM, lanes, watchdog
  // ---------------------------------------------------------------------------
  logic [1:0]               state_q, state_d;
  logic [2:0]               drive_q, drive_d;
  logic [2:0]               seen_q, seen_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH_I0-1:0] lane0_q, lane0_d;
  logic [DATA_WIDTH_I1-1:0] lane1_q, lane1_d;
  logic [DATA_WIDTH_I2-1:0] lane2_q, lane2_d;
  logic                     all_seen;
  logic                     load;

  assign o_ready = (count_q != 2'd2);
  assign push    = i_valid & o_ready;
  assign head    = rd_ptr_q ? mem1_q : mem0_q;

  // FIFO next-state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      if (wr_ptr_q) mem1_d = i_data;
      else          mem0_d = i_data;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  assign free_in = {i_free2, i_free1, i_free0};

  // Shift each asynchronous free through its synchronizer chain, then keep one
  // extra delayed copy so that a rising edge can be detected.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sync_d[k]   = {sync_q[k][SYNC_STAGES-2:0], free_in[k]};
      sync_out[k] = sync_q[k][SYNC_STAGES-1];
    end
    dly_d     = sync_out;
    free_edge = sync_out & ~dly_q;
  end

  // A lane counts as complete if it was seen earlier or its edge arrives now.
  assign all_seen = &(seen_q | free_edge);

  // Main sequencing: load/drive, then wait for all frees or time out.
  always_comb begin
    state_d = state_q;
    drive_d = 3'b000;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          load    = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = '0;
        seen_d  = 3'b000;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion has priority over the watchdog in the same cycle.
        if (all_seen) begin
          seen_d = 3'b000;
          if (count_q != 2'd0) begin
            load    = 1'b1;
            state_d = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
          seen_d  = seen_q | free_edge;
          state_d = S_ERR;
        end else begin
          seen_d = seen_q | free_edge;
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end
      default: begin
        // S_ERR: the word that was in flight is dropped. Frees are ignored here.
        if (i_clr_timeout) begin
          seen_d  = 3'b000;
          state_d = S_IDLE;
        end
      end
    endcase
    if (load) drive_d = 3'b111;
  end

  assign pop = load;

  // Lane registers only change when a word is loaded from the FIFO head.
  always_comb begin
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    lane2_d = lane2_q;
    if (load) begin
      lane0_d = head[DATA_WIDTH_I0-1:0];
      lane1_d = head[DATA_WIDTH_I0+DATA_WIDTH_I1-1:DATA_WIDTH_I0];
      lane2_d = head[W-1:DATA_WIDTH_I0+DATA_WIDTH_I1];
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) sync_q[k] <= '0;
      dly_q <= 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) sync_q[k] <= sync_d[k];
      dly_q <= dly_d;
    end
  end

  // FSM, drive, seen, watchdog counter and lane registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      drive_q <= 3'b000;
      seen_q  <= 3'b000;
      cnt_q   <= '0;
      lane0_q <= '0;
      lane1_q <= '0;
      lane2_q <= '0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
    end
  end

  assign o_drive0    = drive_q[0];
  assign o_drive1    = drive_q[1];
  assign o_drive2    = drive_q[2];
  assign o_data0     = lane0_q;
  assign o_data1     = lane1_q;
  assign o_data2     = lane2_q;
  assign o_busy      = (state_q != S_IDLE) | (count_q != 2'd0);
  assign o_timeout   = (state_q == S_ERR);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sync_drive_split3.sv
// Bench for sync_drive_split3: directed words with hand-computed lane values and
// hand-computed timing. A monitor pops the expected queue on every drive pulse.
module tb_sync_drive_split3;

  localparam int I0 = 1;
  localparam int I1 = 3;
  localparam int I2 = 3;
  localparam int W  = I0 + I1 + I2;
  localparam int SS = 2;
  localparam int TO = 30;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_clr_timeout = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic [2:0]    free = 3'b000;
  logic          o_ready, o_drive0, o_drive1, o_drive2, o_busy, o_timeout;
  logic [I0-1:0] o_data0;
  logic [I1-1:0] o_data1;
  logic [I2-1:0] o_data2;
  logic [1:0]    o_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sync_drive_split3 #(
    .DATA_WIDTH_I0(I0), .DATA_WIDTH_I1(I1), .DATA_WIDTH_I2(I2),
    .SYNC_STAGES(SS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_drive0(o_drive0), .o_drive1(o_drive1), .o_drive2(o_drive2),
    .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2),
    .i_free0(free[0]), .i_free1(free[1]), .i_free2(free[2]),
    .i_clr_timeout(i_clr_timeout), .o_busy(o_busy), .o_timeout(o_timeout),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           drive_cnt = 0;
  int           last_drive_cyc = -1;
  logic         prev_drive = 1'b0;
  logic         have_prev = 1'b0;
  logic         saw_timeout = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] mon_cur;
  logic [W-1:0] mon_exp;
  logic         mon_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample away from the active edge and pop one expected word per drive.
  always @(negedge clk) begin
    mon_cur = {o_data2, o_data1, o_data0};
    mon_drv = o_drive0 | o_drive1 | o_drive2;
    if (!rstn) begin
      prev_drive = 1'b0;
      prev_data  = mon_cur;
      have_prev  = 1'b1;
    end else begin
      if (o_timeout) saw_timeout = 1'b1;
      if (mon_drv) begin
        n_cmp++;
        if (!(o_drive0 && o_drive1 && o_drive2)) begin
          n_err++;
          $display("FAIL drive_together: got %b%b%b expected 111", o_drive2, o_drive1, o_drive0);
        end
        n_cmp++;
        if (prev_drive) begin
          n_err++;
          $display("FAIL drive_width: drive high for more than one cycle at cycle %0d", cyc);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_drive: got data %h with nothing expected", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp) begin
            n_err++;
            $display("FAIL lane_data: got %h expected %h", mon_cur, mon_exp);
          end
        end
        drive_cnt++;
        last_drive_cyc = cyc;
      end else if (have_prev && (mon_cur !== prev_data)) begin
        n_cmp++;
        n_err++;
        $display("FAIL data_stable: got %h expected %h (no load)", mon_cur, prev_data);
      end
      prev_drive = mon_drv;
      prev_data  = mon_cur;
      have_prev  = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    int k;
    k = 0;
    i_valid = 1'b1;
    i_data  = d;
    while (!o_ready && k < 200) begin
      step(1);
      k++;
    end
    if (!o_ready) begin
      check("push_ready_timeout", 32'(o_ready), 32'd1);
      i_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(d);
      #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic wait_drives(input int n);
    int k;
    k = 0;
    while (drive_cnt < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (drive_cnt < n) check("wait_drive_timeout", 32'(drive_cnt), 32'(n));
  endtask

  // Raise the masked frees after edge tgt, hold them for 4 cycles, then drop them.
  task automatic free_pulse(input logic [2:0] mask, input int tgt);
    while (cyc < tgt) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) if (mask[i]) free[i] = 1'b1;
    step(4);
    for (int i = 0; i < 3; i++) if (mask[i]) free[i] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (o_busy && k < 300) begin
      step(1);
      k++;
    end
    check(name, 32'(o_busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int base, d, t, x, t_err;

  initial begin
    // Reset values
    rstn = 1'b0;
    step(3);
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_timeout", 32'(o_timeout), 32'd0);
    check("reset_drive", 32'({o_drive2, o_drive1, o_drive0}), 32'd0);
    check("reset_data", 32'({o_data2, o_data1, o_data0}), 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'd0);
    rstn = 1'b1;
    step(2);

    // Single word: lane0=1, lane1=3'b011, lane2=3'b101
    base = drive_cnt;
    push_word(7'b101_011_1);
    t = cyc;
    wait_drives(base + 1);
    check("single_latency", 32'(last_drive_cyc), 32'(t + 1));
    check("single_data0", 32'(o_data0), 32'd1);
    check("single_data1", 32'(o_data1), 32'd3);
    check("single_data2", 32'(o_data2), 32'd5);
    free_pulse(3'b111, cyc + 4);
    wait_idle("single_idle");
    check("single_count", 32'(drive_cnt), 32'(base + 1));
    check("single_state", 32'(o_dbg_state), 32'd0);
    step(4);

    // Burst of 3 words, frees 20 cycles after each drive
    base = drive_cnt;
    push_word(7'h2A);
    push_word(7'h55);
    push_word(7'h13);
    check("burst_ready_low", 32'(o_ready), 32'd0);
    check("burst_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      wait_drives(base + k + 1);
      d = cyc;
      free_pulse(3'b111, d + 20);
      if (k < 2) begin
        wait_drives(base + k + 2);
        check("burst_next_drive", 32'(last_drive_cyc), 32'(d + 20 + SS + 1));
      end
    end
    wait_idle("burst_idle");
    check("burst_count", 32'(drive_cnt), 32'(base + 3));
    step(4);

    // Staggered frees: the second word must wait for free1
    base = drive_cnt;
    push_word(7'h6C);
    push_word(7'h31);
    wait_drives(base + 1);
    d = cyc;
    fork
      free_pulse(3'b001, d + 5);
      free_pulse(3'b100, d + 9);
      free_pulse(3'b010, d + 14);
    join
    wait_drives(base + 2);
    check("stagger_drive", 32'(last_drive_cyc), 32'(d + 14 + SS + 1));
    check("stagger_count", 32'(drive_cnt), 32'(base + 2));
    free_pulse(3'b111, cyc + 4);
    wait_idle("stagger_idle");
    step(4);

    // Watchdog: only free0/free1 come back
    base = drive_cnt;
    push_word(7'h4B);
    push_word(7'h7F);
    wait_drives(base + 1);
    d = cyc;
    free_pulse(3'b011, d + 3);
    t_err = -1;
    for (int k = 0; k < 100 && t_err < 0; k++) begin
      step(1);
      if (o_timeout) t_err = cyc;
    end
    check("wd_fire_cycle", 32'(t_err), 32'(d + TO + 2));
    free_pulse(3'b100, cyc + 1);
    step(4);
    check("wd_late_free_ignored", 32'(o_timeout), 32'd1);
    check("wd_no_drive_in_err", 32'(drive_cnt), 32'(base + 1));
    x = cyc;
    i_clr_timeout = 1'b1;
    step(1);
    i_clr_timeout = 1'b0;
    wait_drives(base + 2);
    check("wd_clr_drive", 32'(last_drive_cyc), 32'(x + 2));
    check("wd_clr_timeout", 32'(o_timeout), 32'd0);
    step(2);
    i_clr_timeout = 1'b1;
    step(1);
    i_clr_timeout = 1'b0;
    step(1);
    check("clr_outside_err_state", 32'(o_dbg_state), 32'd2);
    check("clr_outside_err_busy", 32'(o_busy), 32'd1);
    free_pulse(3'b111, cyc + 1);
    wait_idle("wd_idle");
    step(4);

    // Completion and timeout on the same edge: completion wins
    base = drive_cnt;
    push_word(7'h5A);
    push_word(7'h25);
    wait_drives(base + 1);
    d = cyc;
    saw_timeout = 1'b0;
    free_pulse(3'b111, d + TO - 1);
    wait_drives(base + 2);
    check("tie_drive", 32'(last_drive_cyc), 32'(d + TO + 2));
    check("tie_no_timeout", 32'(saw_timeout), 32'd0);
    free_pulse(3'b111, cyc + 4);
    wait_idle("tie_idle");
    step(4);

    // Reset during WAIT with two words queued
    base = drive_cnt;
    push_word(7'h0F);
    push_word(7'h70);
    push_word(7'h3C);
    wait_drives(base + 1);
    step(3);
    rstn = 1'b0;
    #1;
    check("rst_mid_ready", 32'(o_ready), 32'd1);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_drive", 32'({o_drive2, o_drive1, o_drive0}), 32'd0);
    check("rst_mid_data", 32'({o_data2, o_data1, o_data0}), 32'd0);
    check("rst_mid_timeout", 32'(o_timeout), 32'd0);
    exp_q.delete();
    step(1);
    rstn = 1'b1;
    step(20);
    check("rst_no_drive", 32'(drive_cnt), 32'(base + 1));
    check("rst_idle_busy", 32'(o_busy), 32'd0);
    check("rst_idle_ready", 32'(o_ready), 32'd1);

    // Final report
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute bound on the run.
  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL global_time_limit: bench did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
